gp_register_file: RTL and testbench
===================================

Name: gp_register_file

Overview:
- Parametrised successor to the single-purpose A/B registers of the SAP-1.5 datapath.
- NUM_REGS general-purpose registers, each WIDTH bits wide.
- Each register loads from the shared bus and supports in-place increment, decrement and clear.
- Two combinational read ports feed the ALU and the bus driver.
- Per-register zero flags and a sticky wrap flag feed the control unit for conditional jumps and loop counters.

Parameters:
- WIDTH, 8, data width of each register.
- NUM_REGS, 4, number of registers; must be at least 2.
- RESET_VALUE, 0, value every register takes on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  write bus_in into the register selected by load_sel.
- load_sel  input  SEL_W  register index for load.
- bus_in  input  WIDTH  data from the shared bus.
- op  input  2  in-place operation: 00 NONE, 01 INC, 10 DEC, 11 CLR.
- op_sel  input  SEL_W  register index for op.
- rd_sel_a  input  SEL_W  read port A index.
- rd_sel_b  input  SEL_W  read port B index.
- rd_data_a  output  WIDTH  contents of register rd_sel_a.
- rd_data_b  output  WIDTH  contents of register rd_sel_b.
- zero_flags  output  NUM_REGS  bit i = (reg[i] == 0).
- wrap  output  1  sticky flag; set when an INC or DEC wraps.
- SEL_W = max(1, $clog2(NUM_REGS)).

Behaviour:
- **Reset:** reset is asynchronous and active-high.
  - While asserted, all registers = RESET_VALUE and wrap = 0.
  - rd_data_a/b and zero_flags follow combinationally from those values; with the default RESET_VALUE, zero_flags = all ones.
  - Reset asserted mid-operation overrides any load or op in flight.
  - The first update after deassertion happens on the next rising edge.
- **Reads:** combinational from registered state. A write is visible on the read ports the cycle after its edge; there is no write-through bypass.
- **Load:** the selected register takes bus_in at the rising edge. Latency is 1 cycle.
- **INC:** reg = reg + 1 modulo 2^WIDTH. If the old value was all ones, wrap is set to 1.
- **DEC:** reg = reg - 1 modulo 2^WIDTH. If the old value was 0, wrap is set to 1 (result is all ones).
- **CLR:** reg = 0. wrap is unaffected.
- **wrap is sticky:**
  - It stays set until a load to any register, or reset, clears it.
  - If a load and a wrapping op occur in the same cycle, the set wins (wrap = 1).
- **Simultaneous load and op, same register** (load_sel == op_sel): load wins, op is discarded, and the op causes no wrap set.
- **Simultaneous load and op, different registers:** both take effect in the same cycle.
- **Out-of-range selects** (index >= NUM_REGS when NUM_REGS is not a power of 2):
  - A load or op to such an index is ignored and leaves state unchanged.
  - A read from such an index returns 0.
- **No handshake:** the control unit asserts load/op for exactly the cycles it intends. Holding op = INC for N cycles increments N times.

Decomposition:
- Shared package (e.g. in alongside test_utils_pkg, in an rtl-side package): enum reg_op_e {OP_NONE, OP_INC, OP_DEC, OP_CLR} at 2 bits, and a function computing SEL_W.
- One natural sub-module: gp_register_cell.
  - One WIDTH-bit register with load/inc/dec/clr.
  - Outputs its value, its zero flag and a wrap_event pulse.
  - The top level instantiates NUM_REGS cells in a generate loop, decodes selects, muxes the read ports and holds the sticky wrap flop.

Test Plan:
1. **Reset values:** assert reset mid-cycle (async) with a load pending.
   - Expected: all rd_data = 0x00, zero_flags = 4'b1111, wrap = 0 before the next edge.
   - Expected: after release, the first edge performs the load.
2. **Load and read latency:** load=1, load_sel=0, bus_in=0x44; next cycle load_sel=1, bus_in=0x22.
   - Expected: rd_data_a (sel 0) = 0x44 one cycle after the first edge; rd_data_b (sel 1) = 0x22 after the second.
   - Expected: zero_flags = 4'b1100.
3. **Increment wrap:** load reg2 = 0xFE, then op=INC on reg2 for 3 cycles.
   - Expected: values 0xFF, 0x00, 0x01.
   - Expected: wrap = 1 from the edge producing 0x00 and stays 1; zero_flags[2] high for exactly one cycle.
   - Expected: a subsequent load to reg0 clears wrap.
4. **Decrement wrap:** load reg3 = 0x01, then DEC for 2 cycles.
   - Expected: values 0x00, 0xFF; wrap = 1 after the second edge.
   - Expected: CLR on reg3 gives 0x00 with wrap still 1.
5. **Collision:** load_sel = op_sel = 1, bus_in = 0x10, op = INC.
   - Expected: reg1 = 0x10, not 0x11.
   - Same cycle with op_sel = 2 (reg2 = 0x05, INC): expected reg1 = 0x10 and reg2 = 0x06.
6. **Out of range:** with NUM_REGS = 3 (SEL_W = 2), load to index 3 with 0xAA.
   - Expected: no register changes.
   - Expected: rd_sel_a = 3 reads 0x00; zero_flags width = 3.

Source files
------------

// File: rtl/gp_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gp_register_file_pkg
// Description : Shared types and helpers for the general-purpose register
//               file. Holds the in-place operation encoding and the function
//               that sizes the register-select fields.
// Revision    : 1.0 - initial release
// ============================================================================
package gp_register_file_pkg;

  // In-place operation applied to the register chosen by op_sel.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } reg_op_e;

  // Width of a register-select field. A single bit is kept even for tiny
  // files so that the select ports never collapse to zero width.
  function automatic int gp_sel_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gp_register_cell.sv
`default_nettype none
// ============================================================================
// Module      : gp_register_cell
// Description : One WIDTH-bit register supporting load, increment, decrement
//               and clear. Reports its value, a zero flag and a one-cycle
//               wrap_event when an INC/DEC crosses the all-ones/zero boundary.
// Ports       : clk            - system clock
//               reset          - asynchronous active-high reset
//               load_i         - take load_data_i on the next rising edge
//               load_data_i    - data to load
//               op_i           - in-place operation (ignored when loading)
//               value_o        - current register contents
//               zero_o         - value_o == 0
//               wrap_event_o   - the operation applied this cycle wraps
// Revision    : 1.0 - initial release
// ============================================================================
module gp_register_cell
  import gp_register_file_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  reg_op_e          op_i,
  output logic [WIDTH-1:0] value_o,
  output logic             zero_o,
  output logic             wrap_event_o
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             wrap_event;

  // A load pre-empts the operation entirely, so a discarded op can never
  // raise a wrap event.
  always_comb begin
    value_d    = value_q;
    wrap_event = 1'b0;
    if (load_i) begin
      value_d = load_data_i;
    end else begin
      case (op_i)
        OP_INC: begin
          value_d    = value_q + C_ONE;
          wrap_event = &value_q;
        end
        OP_DEC: begin
          value_d    = value_q - C_ONE;
          wrap_event = ~|value_q;
        end
        OP_CLR: begin
          value_d = '0;
        end
        default: begin
          value_d = value_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= RESET_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o      = value_q;
  assign zero_o       = ~|value_q;
  assign wrap_event_o = wrap_event;

endmodule
`default_nettype wire

// File: rtl/gp_register_file.sv
`default_nettype none
// ============================================================================
// Module      : gp_register_file
// Description : NUM_REGS general-purpose registers of WIDTH bits. Each loads
//               from the shared bus and supports in-place INC/DEC/CLR. Two
//               combinational read ports, per-register zero flags and a
//               sticky wrap flag for loop counters and conditional jumps.
// Ports       : clk        - system clock, rising-edge updates
//               reset      - asynchronous active-high reset
//               load       - write bus_in into register load_sel
//               load_sel   - register index for load
//               bus_in     - shared bus data
//               op         - 00 NONE, 01 INC, 10 DEC, 11 CLR
//               op_sel     - register index for op
//               rd_sel_a/b - read port indices
//               rd_data_a/b- read port data (0 for out-of-range index)
//               zero_flags - bit i set when register i is zero
//               wrap       - sticky, set by a wrapping INC/DEC
// Revision    : 1.0 - initial release
// ============================================================================
module gp_register_file
  import gp_register_file_pkg::*;
#(
  parameter int                 WIDTH       = 8,
  parameter int                 NUM_REGS    = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                SEL_W       = gp_sel_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SEL_W-1:0]    load_sel,
  input  logic [WIDTH-1:0]    bus_in,
  input  logic [1:0]          op,
  input  logic [SEL_W-1:0]    op_sel,
  input  logic [SEL_W-1:0]    rd_sel_a,
  input  logic [SEL_W-1:0]    rd_sel_b,
  output logic [WIDTH-1:0]    rd_data_a,
  output logic [WIDTH-1:0]    rd_data_b,
  output logic [NUM_REGS-1:0] zero_flags,
  output logic                wrap
);

  reg_op_e             op_e;
  logic [WIDTH-1:0]    values [NUM_REGS];
  logic [NUM_REGS-1:0] load_hits;
  logic [NUM_REGS-1:0] wrap_events;
  logic                wrap_q;
  logic                wrap_d;

  assign op_e = reg_op_e'(op);

  // Select decode happens per cell; an out-of-range index matches no cell,
  // so such loads and ops fall through without touching any state.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cells
    reg_op_e cell_op;

    assign load_hits[i] = load && (load_sel == SEL_W'(i));
    assign cell_op      = (op_sel == SEL_W'(i)) ? op_e : OP_NONE;

    gp_register_cell #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .load_i       (load_hits[i]),
      .load_data_i  (bus_in),
      .op_i         (cell_op),
      .value_o      (values[i]),
      .zero_o       (zero_flags[i]),
      .wrap_event_o (wrap_events[i])
    );
  end

  // A wrap in the same cycle as a clearing load must leave the flag set,
  // hence the set term is OR-ed in after the clear.
  always_comb begin
    wrap_d = wrap_q;
    if (|load_hits) begin
      wrap_d = 1'b0;
    end
    if (|wrap_events) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  // Read ports default to zero so an unmatched index reads as 0.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_a == SEL_W'(i)) begin
        rd_data_a = values[i];
      end
      if (rd_sel_b == SEL_W'(i)) begin
        rd_data_b = values[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gp_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_register_file
// Description : Self-checking bench for gp_register_file. A 4-register
//               instance is driven from a table of directed vectors; a
//               3-register instance covers out-of-range selects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gp_register_file;

  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] I = 2'b01;
  localparam logic [1:0] D = 2'b10;
  localparam logic [1:0] C = 2'b11;

  typedef struct {
    logic       ld;
    logic [1:0] ls;
    logic [7:0] bus;
    logic [1:0] op;
    logic [1:0] os;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [3:0] ez;
    logic       ew;
  } vec_t;

  logic       clk;
  logic       reset;

  logic       load;
  logic [1:0] load_sel;
  logic [7:0] bus_in;
  logic [1:0] op;
  logic [1:0] op_sel;
  logic [1:0] rd_sel_a;
  logic [1:0] rd_sel_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic [3:0] zero_flags;
  logic       wrap;

  logic       load3;
  logic [1:0] load_sel3;
  logic [7:0] bus_in3;
  logic [1:0] op3;
  logic [1:0] op_sel3;
  logic [1:0] rd_sel_a3;
  logic [1:0] rd_sel_b3;
  logic [7:0] rd_data_a3;
  logic [7:0] rd_data_b3;
  logic [2:0] zero_flags3;
  logic       wrap3;

  int total;
  int bad;

  vec_t tbl [20];

  gp_register_file #(.WIDTH(8), .NUM_REGS(4), .RESET_VALUE(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_sel   (load_sel),
    .bus_in     (bus_in),
    .op         (op),
    .op_sel     (op_sel),
    .rd_sel_a   (rd_sel_a),
    .rd_sel_b   (rd_sel_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .zero_flags (zero_flags),
    .wrap       (wrap)
  );

  gp_register_file #(.WIDTH(8), .NUM_REGS(3), .RESET_VALUE(8'h00)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .load       (load3),
    .load_sel   (load_sel3),
    .bus_in     (bus_in3),
    .op         (op3),
    .op_sel     (op_sel3),
    .rd_sel_a   (rd_sel_a3),
    .rd_sel_b   (rd_sel_b3),
    .rd_data_a  (rd_data_a3),
    .rd_data_b  (rd_data_b3),
    .zero_flags (zero_flags3),
    .wrap       (wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [1:0] ls,
                              input logic [7:0] bus, input logic [1:0] o,
                              input logic [1:0] os, input logic [1:0] ra,
                              input logic [1:0] rb, input logic [7:0] ea,
                              input logic [7:0] eb, input logic [3:0] ez,
                              input logic ew);
    vec_t v;
    v.ld = ld; v.ls = ls; v.bus = bus; v.op = o; v.os = os;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.ez = ez; v.ew = ew;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // State entering the table: r0=00 r1=33 r2=00 r3=00, wrap=0.
    tbl[0]  = mk(1, 0, 8'h44, N, 0, 0, 1, 8'h44, 8'h33, 4'b1100, 0);
    tbl[1]  = mk(1, 1, 8'h22, N, 0, 0, 1, 8'h44, 8'h22, 4'b1100, 0);
    tbl[2]  = mk(1, 2, 8'hFE, N, 0, 2, 0, 8'hFE, 8'h44, 4'b1000, 0);
    tbl[3]  = mk(0, 0, 8'h00, I, 2, 2, 0, 8'hFF, 8'h44, 4'b1000, 0);
    tbl[4]  = mk(0, 0, 8'h00, I, 2, 2, 0, 8'h00, 8'h44, 4'b1100, 1);
    tbl[5]  = mk(0, 0, 8'h00, I, 2, 2, 0, 8'h01, 8'h44, 4'b1000, 1);
    tbl[6]  = mk(0, 0, 8'h00, N, 0, 2, 0, 8'h01, 8'h44, 4'b1000, 1);
    tbl[7]  = mk(1, 0, 8'h07, N, 0, 0, 2, 8'h07, 8'h01, 4'b1000, 0);
    tbl[8]  = mk(1, 3, 8'h01, N, 0, 3, 0, 8'h01, 8'h07, 4'b0000, 0);
    tbl[9]  = mk(0, 0, 8'h00, D, 3, 3, 1, 8'h00, 8'h22, 4'b1000, 0);
    tbl[10] = mk(0, 0, 8'h00, D, 3, 3, 1, 8'hFF, 8'h22, 4'b0000, 1);
    tbl[11] = mk(0, 0, 8'h00, C, 3, 3, 1, 8'h00, 8'h22, 4'b1000, 1);
    tbl[12] = mk(1, 2, 8'h05, N, 0, 2, 3, 8'h05, 8'h00, 4'b1000, 0);
    tbl[13] = mk(1, 1, 8'h10, I, 1, 1, 2, 8'h10, 8'h05, 4'b1000, 0);
    tbl[14] = mk(1, 1, 8'h20, I, 2, 1, 2, 8'h20, 8'h06, 4'b1000, 0);
    tbl[15] = mk(1, 3, 8'h40, D, 3, 3, 0, 8'h40, 8'h07, 4'b0000, 0);
    tbl[16] = mk(0, 0, 8'h00, C, 0, 0, 3, 8'h00, 8'h40, 4'b0001, 0);
    tbl[17] = mk(1, 1, 8'h99, D, 0, 0, 1, 8'hFF, 8'h99, 4'b0000, 1);
    tbl[18] = mk(0, 0, 8'h00, I, 0, 0, 1, 8'h00, 8'h99, 4'b0001, 1);
    tbl[19] = mk(0, 0, 8'h00, N, 0, 3, 2, 8'h40, 8'h06, 4'b0001, 1);

    reset    = 1'b1;
    load     = 1'b0; load_sel  = '0; bus_in  = '0; op  = N; op_sel  = '0;
    rd_sel_a = 2'd0; rd_sel_b  = 2'd1;
    load3    = 1'b0; load_sel3 = '0; bus_in3 = '0; op3 = N; op_sel3 = '0;
    rd_sel_a3 = 2'd0; rd_sel_b3 = 2'd1;

    // Reset state while held.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_a", 0, 32'(rd_data_a), 32'h00);
    chk("reset_zero", 0, 32'(zero_flags), 32'hF);
    chk("reset_wrap", 0, 32'(wrap), 32'h0);

    // Release and load r0 so the async reset has something to clear.
    reset  = 1'b0;
    load   = 1'b1; load_sel = 2'd0; bus_in = 8'h5A;
    step();
    chk("pre_reset_r0", 0, 32'(rd_data_a), 32'h5A);

    // Async reset mid-cycle with a load to r1 pending.
    load_sel = 2'd1; bus_in = 8'h33;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rd_a", 1, 32'(rd_data_a), 32'h00);
    chk("async_rd_b", 1, 32'(rd_data_b), 32'h00);
    chk("async_zero", 1, 32'(zero_flags), 32'hF);
    chk("async_wrap", 1, 32'(wrap), 32'h0);
    reset = 1'b0;
    step();
    load = 1'b0;
    chk("post_reset_load", 1, 32'(rd_data_b), 32'h33);
    chk("post_reset_r0", 1, 32'(rd_data_a), 32'h00);

    // Table-driven main sequence.
    for (int k = 0; k < 20; k++) begin
      load     = tbl[k].ld;
      load_sel = tbl[k].ls;
      bus_in   = tbl[k].bus;
      op       = tbl[k].op;
      op_sel   = tbl[k].os;
      rd_sel_a = tbl[k].ra;
      rd_sel_b = tbl[k].rb;
      step();
      chk("rd_a", k, 32'(rd_data_a), 32'(tbl[k].ea));
      chk("rd_b", k, 32'(rd_data_b), 32'(tbl[k].eb));
      chk("zero_flags", k, 32'(zero_flags), 32'(tbl[k].ez));
      chk("wrap", k, 32'(wrap), 32'(tbl[k].ew));
    end
    load = 1'b0;
    op   = N;

    // Out-of-range selects on the 3-register instance.
    load3 = 1'b1; load_sel3 = 2'd0; bus_in3 = 8'h11;
    step();
    load_sel3 = 2'd1; bus_in3 = 8'h22;
    step();
    load3 = 1'b0; op3 = D; op_sel3 = 2'd2;
    step();
    rd_sel_a3 = 2'd2;
    #1;
    chk("oor_dec_r2", 0, 32'(rd_data_a3), 32'hFF);
    chk("oor_wrap_set", 0, 32'(wrap3), 32'h1);
    load3 = 1'b1; load_sel3 = 2'd3; bus_in3 = 8'hAA;
    op3 = I; op_sel3 = 2'd3;
    step();
    load3 = 1'b0; op3 = N;
    rd_sel_a3 = 2'd0; rd_sel_b3 = 2'd1;
    #1;
    chk("oor_r0", 0, 32'(rd_data_a3), 32'h11);
    chk("oor_r1", 0, 32'(rd_data_b3), 32'h22);
    rd_sel_a3 = 2'd2; rd_sel_b3 = 2'd3;
    #1;
    chk("oor_r2", 0, 32'(rd_data_a3), 32'hFF);
    chk("oor_read3", 0, 32'(rd_data_b3), 32'h00);
    chk("oor_zero", 0, 32'(zero_flags3), 32'h0);
    chk("oor_wrap_kept", 0, 32'(wrap3), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
